bcd_countdown: RTL

//  Loadable multi-digit BCD down-counter (countdown timer) for the seven-segment display path.
//  It is the decrementing, terminal-count counterpart of the free-running wrap-up counters used
//  for digit scan. It drives BCD digits to the display mux and pulses done when it reaches 0000.
//  An internal prescaler derives the decrement tick from clk.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_digit_dec.sv | 27 ++
 rtl/bcd_countdown.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared types, constants and helpers for the BCD countdown timer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_dec.sv
// ============================================================================
// Module : bcd_digit_dec
// Brief  : Combinational single-digit BCD decrement with borrow (0 -> 9).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_dec (
    input  logic [3:0] d,
    input  logic       en,
    output logic [3:0] q,
    output logic       is_zero
);
    import bcd_pkg::*;

    assign is_zero = (d == 4'd0);

    always_comb begin
        q = d;
        if (en) begin
            q = is_zero ? BCD_MAX : (d - 4'd1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_countdown.sv
// ============================================================================
// Module : bcd_countdown
// Brief  : Loadable multi-digit BCD countdown timer with internal prescaler
//          and one-cycle done pulse. Define BCD_COUNTDOWN_AUTORELOAD_EN for
//          periodic auto-reload from the last loaded value.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_countdown #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 12_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                pause,
    output logic [4*DIGITS-1:0] digits,
    output logic                running,
    output logic                done
);
    import bcd_pkg::*;

    localparam int            W          = BCD_W * DIGITS;
    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t          state_q,   state_d;
    logic [W-1:0]    digits_q,  digits_d;
    logic [PW-1:0]   presc_q,   presc_d;
    logic            running_q, running_d;
    logic            done_q,    done_d;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    logic [W-1:0]    reload_q,  reload_d;
`endif

    logic [W-1:0]      w_dec;
    logic [W-1:0]      w_load_clamped;
    logic [DIGITS-1:0] w_en;
    logic [DIGITS-1:0] w_is_zero;
    logic              w_tick;
    logic              w_unused_msd_zero;

    assign w_tick            = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign w_unused_msd_zero = w_is_zero[DIGITS-1];

    // Borrow ripples upward: a digit decrements only when every lower digit is 0.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsb
            assign w_en[i] = w_tick;
        end else begin : g_upper
            assign w_en[i] = w_en[i-1] & w_is_zero[i-1];
        end

        assign w_load_clamped[i*BCD_W +: BCD_W] = bcd_clamp(load_val[i*BCD_W +: BCD_W]);

        bcd_digit_dec u_dec (
            .d       (digits_q[i*BCD_W +: BCD_W]),
            .en      (w_en[i]),
            .q       (w_dec[i*BCD_W +: BCD_W]),
            .is_zero (w_is_zero[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            digits_d = w_load_clamped;
            presc_d  = '0;
            state_d  = ST_IDLE;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
            reload_d = w_load_clamped;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !pause && (digits_q != '0)) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_PAUSE: begin
                    if (start && !pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The cycle spent in RUN always counts, even on the pause edge.
                    presc_d = w_tick ? '0 : (presc_q + PW'(1));
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end
                    if (w_tick) begin
                        digits_d = w_dec;
                        if (w_dec == '0) begin
                            done_d = 1'b1;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                            digits_d = reload_q;
                            if (reload_q == '0) begin
                                state_d = ST_IDLE;
                            end
`else
                            state_d = ST_IDLE;
`endif
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            digits_q  <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
            reload_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
            reload_q  <= reload_d;
`endif
        end
    end

    assign digits  = digits_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

`default_nettype wire
